// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          SYNC_DEPTH = 2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_lane.sv
// One lamp/button lane: button synchronizer and press detector, lamp flop
// and the on-time down-counter that turns an unanswered lamp into a miss.
module mole_lane
    import mole_pkg::*;
#(
    parameter int ON_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    input  logic spawn,
    input  logic clear_all,
    input  logic enable,
    output logic lamp,
    output logic hit,
    output logic miss
);

    localparam int            TW         = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(ON_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  prev;
    logic                  press;
    logic [TW-1:0]         timer;

    // Press is registered so detection lands two edges after the input fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync  <= '1;
            prev  <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_DEPTH-2:0], btn_n};
            prev  <= sync[SYNC_DEPTH-1];
            press <= prev & ~sync[SYNC_DEPTH-1];
        end
    end

    // A press landing on the expiry cycle wins: it is a hit, not a miss.
    assign hit  = enable & lamp & press;
    assign miss = enable & lamp & ~press & (timer == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            lamp  <= 1'b0;
            timer <= '0;
        end else if (clear_all || hit || miss) begin
            lamp  <= 1'b0;
            timer <= '0;
        end else if (spawn) begin
            lamp  <= 1'b1;
            timer <= TIMER_LOAD;
        end else if (lamp) begin
            timer <= timer - TW'(1);
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: IDLE/PLAY/OVER flow, LFSR lane choice,
// spawn pacing with an active-lamp cap, and a saturating score.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int N_LANES      = 4,
    parameter int SPAWN_CYCLES = 50_000_000,
    parameter int ON_CYCLES    = 100_000_000,
    parameter int MAX_ACTIVE   = 2,
    parameter int WIN_SCORE    = 12,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_n,
    input  logic [N_LANES-1:0] btn_n,
    output logic [N_LANES-1:0] lamp,
    output logic [SCORE_W-1:0] score,
    output logic               in_game,
    output logic               game_over
);

    localparam int                 LW         = $clog2(N_LANES);
    localparam int                 CW         = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
    localparam int                 NW         = $clog2(N_LANES + 1);
    localparam logic [CW-1:0]      SPAWN_LAST = CW'(SPAWN_CYCLES - 1);
    localparam logic [NW-1:0]      ACTIVE_CAP = NW'(MAX_ACTIVE);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    game_state_t           state;
    logic [15:0]           lfsr;
    logic [CW-1:0]         spawn_cnt;
    logic [SYNC_DEPTH-1:0] start_sync;
    logic                  start_prev;
    logic                  start_press;

    logic [N_LANES-1:0]    hit_vec;
    logic [N_LANES-1:0]    miss_vec;
    logic [N_LANES-1:0]    spawn_vec;
    logic [NW-1:0]         lit_cnt;
    logic [NW-1:0]         hit_cnt;
    logic [NW-1:0]         miss_cnt;
    logic [LW-1:0]         spawn_lane;
    logic                  playing;
    logic                  wrap;
    logic                  spawn_ok;
    logic                  clear_all;
    logic                  win;
    logic [SCORE_W:0]      hit_ext;
    logic [SCORE_W:0]      miss_ext;
    logic signed [SCORE_W:0] sum;
    logic [SCORE_W-1:0]    score_upd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            start_sync  <= '1;
            start_prev  <= 1'b1;
            start_press <= 1'b0;
        end else begin
            start_sync  <= {start_sync[SYNC_DEPTH-2:0], start_n};
            start_prev  <= start_sync[SYNC_DEPTH-1];
            start_press <= start_prev & ~start_sync[SYNC_DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        lit_cnt  = '0;
        hit_cnt  = '0;
        miss_cnt = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lit_cnt  = lit_cnt + NW'(lamp[i]);
            hit_cnt  = hit_cnt + NW'(hit_vec[i]);
            miss_cnt = miss_cnt + NW'(miss_vec[i]);
        end
    end

    assign playing    = (state == PLAY);
    assign wrap       = (spawn_cnt == SPAWN_LAST);
    assign spawn_lane = lfsr[LW-1:0];
    // Lit count is taken before this cycle's clears, and a lane that is
    // clearing is still lit, so spawns onto it are dropped.
    assign spawn_ok   = playing && wrap && !lamp[spawn_lane] && (lit_cnt < ACTIVE_CAP);

    always_comb begin
        spawn_vec = '0;
        for (int i = 0; i < N_LANES; i++) begin
            spawn_vec[i] = spawn_ok && (spawn_lane == LW'(i));
        end
    end

    assign hit_ext   = {{(SCORE_W + 1 - NW){1'b0}}, hit_cnt};
    assign miss_ext  = {{(SCORE_W + 1 - NW){1'b0}}, miss_cnt};
    assign sum       = $signed({1'b0, score}) + $signed(hit_ext) - $signed(miss_ext);
    assign score_upd = sum[SCORE_W] ? '0 : sum[SCORE_W-1:0];
    assign win       = (score_upd >= WIN);
    assign clear_all = (playing && win) || (!playing && start_press);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        mole_lane #(
            .ON_CYCLES(ON_CYCLES)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .btn_n    (btn_n[i]),
            .spawn    (spawn_vec[i]),
            .clear_all(clear_all),
            .enable   (playing),
            .lamp     (lamp[i]),
            .hit      (hit_vec[i]),
            .miss     (miss_vec[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            score     <= '0;
            spawn_cnt <= '0;
            in_game   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start_press) begin
                        state     <= PLAY;
                        score     <= '0;
                        spawn_cnt <= '0;
                        in_game   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    score     <= score_upd;
                    spawn_cnt <= wrap ? '0 : spawn_cnt + CW'(1);
                    if (win) begin
                        state     <= OVER;
                        in_game   <= 1'b0;
                        game_over <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_game   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a cycle-level reference of the game.
module tb_mole_scheduler;

    localparam int N   = 4;
    localparam int S   = 8;
    localparam int ON  = 20;
    localparam int MA  = 2;
    localparam int WIN = 3;
    localparam int SW  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_n = 1'b1;
    logic [N-1:0]  btn_n = '1;
    logic [N-1:0]  lamp;
    logic [SW-1:0] score;
    logic          in_game;
    logic          game_over;

    int vectors = 0;
    int miscompares = 0;
    int max_lit = 0;

    int           m_state;
    int           m_cnt;
    int           m_score;
    logic [N-1:0] m_lamp;
    int           m_tmr[N];
    logic [15:0]  m_lfsr;

    always #5 clk = ~clk;

    mole_scheduler #(
        .N_LANES(N), .SPAWN_CYCLES(S), .ON_CYCLES(ON),
        .MAX_ACTIVE(MA), .WIN_SCORE(WIN), .SCORE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .start_n(start_n), .btn_n(btn_n),
        .lamp(lamp), .score(score), .in_game(in_game), .game_over(game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the reference one edge, pass the DUT edge, compare at the negedge.
    task automatic adv(input logic [N-1:0] hit_mask, input bit start_eff);
        logic [15:0]  cur;
        logic [N-1:0] nl;
        int h, m, lit, lane;
        if (!reset) begin
            m_state = 0; m_score = 0; m_cnt = 0; m_lamp = '0;
            m_lfsr = 16'hACE1;
            for (int i = 0; i < N; i++) m_tmr[i] = 0;
        end else begin
            cur = m_lfsr;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            if (m_state != 1) begin
                if (start_eff) begin
                    m_state = 1; m_score = 0; m_cnt = 0; m_lamp = '0;
                    for (int i = 0; i < N; i++) m_tmr[i] = 0;
                end
            end else begin
                h = 0; m = 0; lit = $countones(m_lamp); nl = m_lamp;
                for (int i = 0; i < N; i++) begin
                    if (m_lamp[i]) begin
                        if (hit_mask[i]) begin h++; nl[i] = 1'b0; end
                        else if (m_tmr[i] == 0) begin m++; nl[i] = 1'b0; end
                        else m_tmr[i]--;
                    end
                end
                if (m_cnt == S - 1) begin
                    lane = int'(cur[1:0]);
                    if (!m_lamp[lane] && lit < MA) begin nl[lane] = 1'b1; m_tmr[lane] = ON - 1; end
                end
                m_cnt = (m_cnt == S - 1) ? 0 : m_cnt + 1;
                m_score = m_score + h - m;
                if (m_score < 0) m_score = 0;
                m_lamp = nl;
                if (m_score >= WIN) begin m_state = 2; m_lamp = '0; end
            end
        end
        @(negedge clk);
        if ($countones(lamp) > max_lit) max_lit = $countones(lamp);
        check("lamp", 32'(lamp), 32'(m_lamp));
        check("score", 32'(score), 32'(m_score));
        check("in_game", 32'(in_game), 32'(m_state == 1));
        check("game_over", 32'(game_over), 32'(m_state == 2));
    endtask

    task automatic tick();
        adv('0, 1'b0);
    endtask

    task automatic press(input logic [N-1:0] mask);
        btn_n = ~mask; tick();
        btn_n = '1;    tick(); tick();
        adv(mask, 1'b0);
    endtask

    task automatic start_press();
        start_n = 1'b0; tick();
        start_n = 1'b1; tick(); tick();
        adv('0, 1'b1);
    endtask

    initial begin
        int t, hi, l, sc0;
        bit found;
        logic [N-1:0] mk;

        // Reset values
        reset = 1'b0;
        repeat (3) tick();
        check("rst_lamp", 32'(lamp), 0);
        check("rst_score", 32'(score), 0);
        check("rst_in_game", 32'(in_game), 0);
        check("rst_game_over", 32'(game_over), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Start: in_game rises on the third edge after the sampled fall
        start_n = 1'b0; tick();
        start_n = 1'b1; tick(); tick();
        check("start_edge2_in_game", 32'(in_game), 0);
        adv('0, 1'b1);
        check("start_edge3_in_game", 32'(in_game), 1);
        check("start_score", 32'(score), 0);

        // First spawn eight cycles after PLAY entry
        t = 0;
        while (lamp == '0 && t < 20) begin tick(); t++; end
        check("first_spawn_cycle", t, 8);

        // Untouched lamp stays lit exactly ON cycles; misses saturate at 0
        l = 0;
        for (int j = N - 1; j >= 0; j--) if (m_lamp[j]) l = j;
        hi = 1;
        for (int i = 0; i < 40 && lamp[l]; i++) begin tick(); if (lamp[l]) hi++; end
        check("lit_duration", hi, ON);
        check("miss_score", 32'(score), 0);
        repeat (40) tick();
        check("second_miss_score", 32'(score), 0);

        // Hit landing on the lane's expiry cycle counts as a hit
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            for (int j = 0; j < N; j++)
                if (!found && m_lamp[j] && m_tmr[j] == 3) begin found = 1; l = j; end
            if (!found) tick();
        end
        check("expiry_wait", 32'(found), 1);
        mk = '0; mk[l] = 1'b1;
        press(mk);
        check("expiry_hit_lamp", 32'(lamp[l]), 0);

        // Press on an unlit lane, clear of any spawn in the press window
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_cnt == 1) found = 1; else tick();
        end
        check("unlit_wait", 32'(found), 1);
        l = 0;
        for (int j = N - 1; j >= 0; j--) if (!m_lamp[j]) l = j;
        mk = '0; mk[l] = 1'b1;
        press(mk);
        check("unlit_lamp_dark", 32'(lamp[l]), 0);

        // Two lit lanes pressed together: +2 in one update
        found = 0;
        for (int i = 0; i < 200 && !found && m_state == 1; i++) begin
            found = ($countones(m_lamp) == 2);
            for (int j = 0; j < N; j++) if (m_lamp[j] && m_tmr[j] < 4) found = 0;
            if (!found) tick();
        end
        check("dual_wait", 32'(found), 1);
        sc0 = m_score;
        press(m_lamp);
        check("dual_hit_score", 32'(score), 32'(sc0 + 2));
        check("dual_hit_lamps", 32'(lamp), 0);

        // Keep hitting until the game ends
        for (int i = 0; i < 60 && m_state == 1; i++) begin
            found = 0;
            for (int j = 0; j < N; j++)
                if (!found && m_lamp[j] && m_tmr[j] >= 4) begin found = 1; l = j; end
            if (found) begin mk = '0; mk[l] = 1'b1; press(mk); end
            else tick();
        end
        check("over_game_over", 32'(game_over), 1);
        check("over_in_game", 32'(in_game), 0);
        check("over_lamps", 32'(lamp), 0);
        check("over_score_reached", 32'(score >= WIN), 1);

        // Buttons ignored in OVER
        sc0 = m_score;
        press('1);
        check("over_btn_score", 32'(score), 32'(sc0));
        check("over_btn_lamps", 32'(lamp), 0);

        // Restart from OVER
        start_press();
        check("restart_in_game", 32'(in_game), 1);
        check("restart_score", 32'(score), 0);
        check("restart_game_over", 32'(game_over), 0);
        repeat (12) tick();

        // Reset mid-game
        reset = 1'b0;
        tick();
        check("midrst_lamp", 32'(lamp), 0);
        check("midrst_score", 32'(score), 0);
        check("midrst_in_game", 32'(in_game), 0);
        check("midrst_game_over", 32'(game_over), 0);
        reset = 1'b1;
        repeat (2) tick();

        check("max_lit_cap", 32'(max_lit <= MA), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
